// File: rtl/operand_pingpong_mem_pkg.sv
// Shared constants and types for the operand ping-pong memory.
//   PP_VL / PP_VEC_W / PP_ADDR_W : default geometry (lanes, lane width, address bits)
//   PP_BANKS                     : number of ping-pong banks
//   pp_state_e                   : compute-side FSM encoding (IDLE / RUN)
package operand_pingpong_mem_pkg;

  localparam int PP_VL     = 16;
  localparam int PP_VEC_W  = 32;
  localparam int PP_ADDR_W = 8;
  localparam int PP_BANKS  = 2;

  typedef enum logic {
    PP_IDLE = 1'b0,
    PP_RUN  = 1'b1
  } pp_state_e;

endpackage

// File: rtl/operand_pingpong_mem_pp_bank_ram.sv
// pp_bank_ram: one bank of one operand array.
// 1-write / 1-read synchronous RAM with a registered read port.
//   i_clk, i_rst_n : clock, async active-low reset (read register only)
//   i_we, i_waddr, i_wdata : write port
//   i_raddr        : read address, data appears on o_rdata one cycle later
//   o_rdata        : registered read data (cleared by reset)
// Array contents are never reset.
module operand_pingpong_mem_pp_bank_ram #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WIDTH-1:0]  i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [WIDTH-1:0]  o_rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_rdata <= '0;
    else          r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/operand_pingpong_mem.sv
// operand_pingpong_mem: double-buffered operand store between host/DMA and
// the matrix accelerator. The host fills the load bank and commits it; the
// compute FSM issues a start pulse for each full bank, serves A/B reads from
// the compute bank and frees it on i_mtrx_done.
// Ports:
//   i_clk, i_rst_n                 clock, async active-low reset
//   i_host_we/sel/addr/data        host write (sel 0 = A array, 1 = B array)
//   i_host_commit, o_host_ready    hand the load bank to compute / load bank free
//   i_a_addr, o_a_data             A (VL-lane) read, 1-cycle latency
//   i_b_addr, o_b_data             B (scalar) read, 1-cycle latency
//   i_mtrx_done                    compute bank consumed
//   o_start, o_busy                start pulse / FSM in RUN (o_busy is the FSM state)
//   o_wr_drop                      sticky: write or commit attempted while not ready
// Handshake: the host may write or commit only in a cycle where o_host_ready
// is high; attempts while it is low are dropped and flagged in o_wr_drop.
module operand_pingpong_mem
  import operand_pingpong_mem_pkg::*;
#(
  parameter int VL     = PP_VL,
  parameter int VEC_W  = PP_VEC_W,
  parameter int ADDR_W = PP_ADDR_W
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_host_we,
  input  logic                 i_host_sel,
  input  logic [ADDR_W-1:0]    i_host_addr,
  input  logic [VEC_W*VL-1:0]  i_host_data,
  input  logic                 i_host_commit,
  output logic                 o_host_ready,
  input  logic [ADDR_W-1:0]    i_a_addr,
  input  logic [ADDR_W-1:0]    i_b_addr,
  output logic [VEC_W*VL-1:0]  o_a_data,
  output logic [VEC_W-1:0]     o_b_data,
  input  logic                 i_mtrx_done,
  output logic                 o_start,
  output logic                 o_busy,
  output logic                 o_wr_drop
);

  localparam int A_W = VEC_W * VL;

  pp_state_e           r_state, w_state_nxt;
  logic [PP_BANKS-1:0] r_full, w_full_nxt;
  logic                r_load_bank, r_comp_bank, r_rd_bank;
  logic                r_start, r_wr_drop;
  logic                w_host_ready, w_write_ok, w_commit_ok;
  logic                w_start_set, w_release, w_busy;

  logic [A_W-1:0]   w_a_rd [PP_BANKS];
  logic [VEC_W-1:0] w_b_rd [PP_BANKS];

  assign w_host_ready = ~r_full[r_load_bank];
  assign w_write_ok   = i_host_we & w_host_ready;
  assign w_commit_ok  = i_host_commit & w_host_ready;

  // Four RAMs: A and B for each bank. Only the load bank is written; every
  // bank reads at the mm_ctrl addresses and the compute bank is picked after
  // the read register.
  for (genvar g = 0; g < PP_BANKS; g++) begin : g_bank
    logic w_bank_wr;
    assign w_bank_wr = w_write_ok & (r_load_bank == 1'(g));

    operand_pingpong_mem_pp_bank_ram #(.WIDTH(A_W), .ADDR_W(ADDR_W)) u_a_ram (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_we    (w_bank_wr & ~i_host_sel),
      .i_waddr (i_host_addr),
      .i_wdata (i_host_data),
      .i_raddr (i_a_addr),
      .o_rdata (w_a_rd[g])
    );

    operand_pingpong_mem_pp_bank_ram #(.WIDTH(VEC_W), .ADDR_W(ADDR_W)) u_b_ram (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_we    (w_bank_wr & i_host_sel),
      .i_waddr (i_host_addr),
      .i_wdata (i_host_data[VEC_W-1:0]),
      .i_raddr (i_b_addr),
      .o_rdata (w_b_rd[g])
    );
  end

  // FSM: state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= PP_IDLE;
    else          r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      PP_IDLE: if (r_full[r_comp_bank]) w_state_nxt = PP_RUN;
      PP_RUN:  if (i_mtrx_done)         w_state_nxt = PP_IDLE;
      default: w_state_nxt = PP_IDLE;
    endcase
  end

  // FSM: outputs. Done outside RUN is ignored.
  always_comb begin
    w_start_set = 1'b0;
    w_release   = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      PP_IDLE: w_start_set = r_full[r_comp_bank];
      PP_RUN: begin
        w_busy    = 1'b1;
        w_release = i_mtrx_done;
      end
      default: ;
    endcase
  end

  // Release and commit never hit the same bank: in RUN the compute bank is
  // full, so if load_bank equals it the host is not ready.
  always_comb begin
    w_full_nxt = r_full;
    if (w_release)   w_full_nxt[r_comp_bank] = 1'b0;
    if (w_commit_ok) w_full_nxt[r_load_bank] = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_full      <= '0;
      r_load_bank <= 1'b0;
      r_comp_bank <= 1'b0;
      r_rd_bank   <= 1'b0;
      r_start     <= 1'b0;
      r_wr_drop   <= 1'b0;
    end else begin
      r_full      <= w_full_nxt;
      r_load_bank <= r_load_bank ^ w_commit_ok;
      r_comp_bank <= r_comp_bank ^ w_release;
      // Read data registered at this edge came from the current compute bank.
      r_rd_bank   <= r_comp_bank;
      r_start     <= w_start_set;
      r_wr_drop   <= r_wr_drop | ((i_host_we | i_host_commit) & ~w_host_ready);
    end
  end

  assign o_host_ready = w_host_ready;
  assign o_a_data     = w_a_rd[r_rd_bank];
  assign o_b_data     = w_b_rd[r_rd_bank];
  assign o_start      = r_start;
  assign o_busy       = w_busy;
  assign o_wr_drop    = r_wr_drop;

endmodule

// File: tb/tb_operand_pingpong_mem.sv
module tb_operand_pingpong_mem;

  localparam int VL     = 16;
  localparam int VEC_W  = 32;
  localparam int ADDR_W = 8;
  localparam int A_W    = VL * VEC_W;

  logic              clk;
  logic              rst_n;
  logic              host_we;
  logic              host_sel;
  logic [ADDR_W-1:0] host_addr;
  logic [A_W-1:0]    host_data;
  logic              host_commit;
  logic              host_ready;
  logic [ADDR_W-1:0] a_addr;
  logic [ADDR_W-1:0] b_addr;
  logic [A_W-1:0]    a_data;
  logic [VEC_W-1:0]  b_data;
  logic              mtrx_done;
  logic              start;
  logic              busy;
  logic              wr_drop;

  int checks   = 0;
  int failures = 0;

  logic [A_W-1:0] pat_a5, pat_5a, pat_c3, pat_77, pat_junk;

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  operand_pingpong_mem #(.VL(VL), .VEC_W(VEC_W), .ADDR_W(ADDR_W)) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_host_we     (host_we),
    .i_host_sel    (host_sel),
    .i_host_addr   (host_addr),
    .i_host_data   (host_data),
    .i_host_commit (host_commit),
    .o_host_ready  (host_ready),
    .i_a_addr      (a_addr),
    .i_b_addr      (b_addr),
    .o_a_data      (a_data),
    .o_b_data      (b_data),
    .i_mtrx_done   (mtrx_done),
    .o_start       (start),
    .o_busy        (busy),
    .o_wr_drop     (wr_drop)
  );

  task automatic check(input string tag, input logic [A_W-1:0] obs, input logic [A_W-1:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // advance one clock; inputs change and outputs are sampled 1 ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    host_we     = 1'b0;
    host_commit = 1'b0;
    mtrx_done   = 1'b0;
  endtask

  task automatic host_write(input logic sel, input logic [ADDR_W-1:0] addr, input logic [A_W-1:0] data);
    host_we   = 1'b1;
    host_sel  = sel;
    host_addr = addr;
    host_data = data;
    tick();
    idle_inputs();
  endtask

  task automatic pulse_commit();
    host_commit = 1'b1;
    tick();
    idle_inputs();
  endtask

  task automatic pulse_done();
    mtrx_done = 1'b1;
    tick();
    idle_inputs();
  endtask

  initial begin
    pat_a5   = {VL{32'hA5A5_A5A5}};
    pat_5a   = {VL{32'h5A5A_5A5A}};
    pat_c3   = {VL{32'hC3C3_C3C3}};
    pat_77   = {VL{32'h7777_0001}};
    pat_junk = {VL{32'hDEAD_BEEF}};

    rst_n     = 1'b0;
    host_sel  = 1'b0;
    host_addr = '0;
    host_data = '0;
    a_addr    = '0;
    b_addr    = '0;
    idle_inputs();
    repeat (3) tick();

    check("rst_ready",  A_W'(host_ready), A_W'(1'b1));
    check("rst_start",  A_W'(start),      A_W'(1'b0));
    check("rst_busy",   A_W'(busy),       A_W'(1'b0));
    check("rst_drop",   A_W'(wr_drop),    A_W'(1'b0));
    check("rst_a_data", a_data,           '0);
    check("rst_b_data", A_W'(b_data),     '0);
    rst_n = 1'b1;
    tick();

    // 1: load bank0 and commit; start follows two edges after commit
    host_write(1'b0, 8'd3, pat_a5);
    host_write(1'b1, 8'd0, A_W'(32'h0000_5555));
    pulse_commit();
    check("t1_ready_after_commit", A_W'(host_ready), A_W'(1'b1));
    check("t1_no_start_yet",       A_W'(start),      A_W'(1'b0));
    a_addr = 8'd3;
    b_addr = 8'd0;
    tick();
    check("t1_start_pulse", A_W'(start), A_W'(1'b1));
    check("t1_busy",        A_W'(busy),  A_W'(1'b1));
    check("t1_a3_bank0",    a_data,      pat_a5);
    check("t1_b0_bank0",    A_W'(b_data), A_W'(32'h0000_5555));
    tick();
    check("t1_start_one_cycle", A_W'(start), A_W'(1'b0));

    // 2: fill bank1 while bank0 runs; both full -> not ready, write dropped
    host_write(1'b0, 8'd3, pat_5a);
    host_write(1'b1, 8'd0, A_W'(32'h0000_1234));
    pulse_commit();
    check("t2_ready_low", A_W'(host_ready), A_W'(1'b0));
    check("t2_drop_clear_before", A_W'(wr_drop), A_W'(1'b0));
    host_write(1'b0, 8'd3, pat_junk);
    check("t2_drop_set",     A_W'(wr_drop), A_W'(1'b1));
    check("t2_bank0_intact", a_data,        pat_a5);
    check("t2_no_restart",   A_W'(start),   A_W'(1'b0));
    check("t2_still_busy",   A_W'(busy),    A_W'(1'b1));

    // 3: done on bank0 -> idle, then start for bank1, reads from bank1
    pulse_done();
    check("t3_busy_fall", A_W'(busy),       A_W'(1'b0));
    check("t3_ready",     A_W'(host_ready), A_W'(1'b1));
    check("t3_no_start",  A_W'(start),      A_W'(1'b0));
    tick();
    check("t3_start_bank1", A_W'(start),  A_W'(1'b1));
    check("t3_b0_bank1",    A_W'(b_data), A_W'(32'h0000_1234));
    check("t3_a3_bank1",    a_data,       pat_5a);
    check("t3_drop_sticky", A_W'(wr_drop), A_W'(1'b1));

    // 4: commit bank0 and done on bank1 in the same cycle
    host_write(1'b0, 8'd3, pat_c3);
    host_commit = 1'b1;
    mtrx_done   = 1'b1;
    tick();
    idle_inputs();
    check("t4_busy_fall", A_W'(busy),       A_W'(1'b0));
    check("t4_ready",     A_W'(host_ready), A_W'(1'b1));
    tick();
    check("t4_start_bank0", A_W'(start), A_W'(1'b1));
    check("t4_a3_bank0",    a_data,      pat_c3);
    pulse_done();
    tick();
    check("t4_no_start_empty", A_W'(start), A_W'(1'b0));
    check("t4_idle",           A_W'(busy),  A_W'(1'b0));

    // 5: done in IDLE with nothing full is ignored
    pulse_done();
    check("t5_busy",  A_W'(busy),       A_W'(1'b0));
    check("t5_ready", A_W'(host_ready), A_W'(1'b1));
    tick();
    check("t5_no_start", A_W'(start), A_W'(1'b0));
    // compute pointer must still be bank1: loading bank1 starts it
    a_addr = 8'd7;
    host_write(1'b0, 8'd7, pat_77);
    pulse_commit();
    tick();
    check("t5_start_bank1", A_W'(start), A_W'(1'b1));
    check("t5_a7_bank1",    a_data,      pat_77);

    // 6: both banks full while busy, then reset
    host_write(1'b0, 8'd7, pat_junk);
    pulse_commit();
    check("t6_ready_low", A_W'(host_ready), A_W'(1'b0));
    check("t6_busy",      A_W'(busy),       A_W'(1'b1));
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy",   A_W'(busy),       A_W'(1'b0));
    check("t6_rst_ready",  A_W'(host_ready), A_W'(1'b1));
    check("t6_rst_start",  A_W'(start),      A_W'(1'b0));
    check("t6_rst_drop",   A_W'(wr_drop),    A_W'(1'b0));
    check("t6_rst_a_data", a_data,           '0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("t6_no_start_after_release", A_W'(start), A_W'(1'b0));
    end
    check("t6_idle_after_release", A_W'(busy), A_W'(1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
